data_mem_arbiter: RTL and testbench

Shares the single-port synchronous data memory between the CPU load/store path and the debug/loader port (program download, memory inspection). Sits between the CPU datapath and data memory. Arbitrates each cycle with round-robin priority, supports a debug lock for uninterrupted multi-word transfers, steers read data back to its owner one cycle later, and raises a stall to the CPU whenever its access is not granted.

---
 rtl/data_mem_arbiter.sv | 59 +++++
 tb/tb_data_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous data memory between the CPU and the debug/loader port
// Ports: cpu_* / dbg_* requester ports (req, we, addr, wdata in; gnt, rvalid, rdata out; cpu_stall, dbg_lock),
//        mem_* memory side (wren, addr, wdata out; rdata in, one cycle after the read address).
// Grants are combinational from requests and state; dbg_lock on a granted dbg beat keeps ownership.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {ARB, LOCKED} mode_e;
  typedef enum logic {CPU, DBG} port_e;
  typedef enum logic [1:0] {NONE, RD_CPU, RD_DBG} owner_e;
  mode_e  mode_q;
  port_e  last_q;
  owner_e rd_q;
  // On a tie the port that was not granted last wins; LOCKED shuts the CPU out entirely.
  assign cpu_gnt    = (mode_q == ARB) && cpu_req && (!dbg_req || last_q == DBG);
  assign dbg_gnt    = dbg_req && (mode_q == LOCKED || !cpu_req || last_q == CPU);
  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign mem_wren   = cpu_gnt ? cpu_we : dbg_gnt && dbg_we;
  assign mem_addr   = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
  assign mem_wdata  = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
  assign cpu_rvalid = rd_q == RD_CPU;
  assign dbg_rvalid = rd_q == RD_DBG;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  always_ff @(posedge clk)
    if (rst) begin
      mode_q <= ARB;
      last_q <= DBG;
      rd_q   <= NONE;
    end else begin
      if (dbg_gnt) mode_q <= dbg_lock ? LOCKED : ARB;
      if (cpu_gnt || dbg_gnt) last_q <= cpu_gnt ? CPU : DBG;
      rd_q <= (cpu_gnt && !cpu_we) ? RD_CPU : (dbg_gnt && !dbg_we) ? RD_DBG : NONE;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  logic        clk = 0, rst = 0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_wren;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  int          checks = 0, errors = 0;
  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  // synchronous memory with two preloaded words at 0x10 and 0x14
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= (mem_addr == 32'h10) ? 32'hDEADBEEF :
                 (mem_addr == 32'h14) ? 32'h14141414 : mem[mem_addr[9:2]];
  end
  task automatic drive(input logic r, input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cd, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic dl);
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock = dl;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, mem_wren} !== 5'b0) begin
      $display("FAIL reset_flags got %b want 00000", {cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, mem_wren});
      errors++;
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata);
      errors++;
    end
  endtask
  task automatic test_single_read();
    do_reset();
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b1000 || mem_addr !== 32'h10) begin
      $display("FAIL single_read_gnt got %b addr %h want 1000 addr 10", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall}, mem_addr);
      errors++;
    end
    idle();
    checks++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b10 || cpu_rdata !== 32'hDEADBEEF) begin
      $display("FAIL single_read_data got rv %b data %h want rv 10 data deadbeef", {cpu_rvalid, dbg_rvalid}, cpu_rdata);
      errors++;
    end
    idle();
    checks++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      $display("FAIL single_read_rv_clear got %b want 00", {cpu_rvalid, dbg_rvalid});
      errors++;
    end
  endtask
  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
      else idle();
      if (i < 6) begin
        checks++;
        if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== ((i % 2 == 0) ? 4'b1000 : 4'b0101)) begin
          $display("FAIL contention_gnt[%0d] got %b want %b", i, {cpu_gnt, dbg_gnt, mem_wren, cpu_stall},
                   (i % 2 == 0) ? 4'b1000 : 4'b0101);
          errors++;
        end
      end
      checks++;
      if ({cpu_rvalid, dbg_rvalid} !== ((i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01)) begin
        $display("FAIL contention_rv[%0d] got %b want %b", i, {cpu_rvalid, dbg_rvalid},
                 (i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01);
        errors++;
      end
      if (i > 0) begin
        checks++;
        if (cpu_rdata !== ((i % 2 == 1) ? 32'hDEADBEEF : 32'h14141414)) begin
          $display("FAIL contention_rdata[%0d] got %h want %h", i, cpu_rdata,
                   (i % 2 == 1) ? 32'hDEADBEEF : 32'h14141414);
          errors++;
        end
      end
    end
  endtask
  task automatic test_lock_burst();
    do_reset();
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, 0, 32'h10, 0, 1, 1, 32'h100 + 4 * b, 32'hA0 + b, b < 3);
      checks++;
      if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b0111 || mem_addr !== 32'h100 + 4 * b || mem_wdata !== 32'hA0 + b) begin
        $display("FAIL lock_burst[%0d] got %b %h %h want 0111 %h %h", b, {cpu_gnt, dbg_gnt, mem_wren, cpu_stall},
                 mem_addr, mem_wdata, 32'h100 + 4 * b, 32'hA0 + b);
        errors++;
      end
    end
    drive(0, 1, 0, 32'h10C, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b1000) begin
      $display("FAIL lock_release got %b want 1000", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall});
      errors++;
    end
    idle();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA3) begin
      $display("FAIL lock_burst_readback got rv %b data %h want 1 a3", cpu_rvalid, cpu_rdata);
      errors++;
    end
  endtask
  task automatic test_lock_idle();
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'h1, 1);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b0001 || mem_addr !== 32'h0) begin
        $display("FAIL lock_idle[%0d] got %b addr %h want 0001 addr 0", c, {cpu_gnt, dbg_gnt, mem_wren, cpu_stall}, mem_addr);
        errors++;
      end
    end
    drive(0, 1, 0, 32'h10, 0, 1, 1, 32'h44, 32'h2, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b0111) begin
      $display("FAIL lock_idle_last got %b want 0111", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall});
      errors++;
    end
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b1000) begin
      $display("FAIL lock_idle_release got %b want 1000", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall});
      errors++;
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      $display("FAIL reset_mid_gnt got %b want 1", cpu_gnt);
      errors++;
    end
    drive(0, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
    checks++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin
      $display("FAIL reset_mid_rv got %b want 00", {cpu_rvalid, dbg_rvalid});
      errors++;
    end
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      $display("FAIL reset_mid_tie got %b want 10", {cpu_gnt, dbg_gnt});
      errors++;
    end
    drive(0, 0, 0, 0, 0, 1, 1, 32'h48, 32'h3, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b1000) begin
      $display("FAIL reset_mid_unlock got %b want 1000", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall});
      errors++;
    end
  endtask
  task automatic test_write_read();
    do_reset();
    drive(0, 1, 1, 32'h20, 32'h55, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wren, cpu_stall} !== 4'b1010 || mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin
      $display("FAIL write_drive got %b %h %h want 1010 20 55", {cpu_gnt, dbg_gnt, mem_wren, cpu_stall}, mem_addr, mem_wdata);
      errors++;
    end
    drive(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({cpu_gnt, mem_wren, cpu_rvalid, dbg_rvalid} !== 4'b1000) begin
      $display("FAIL read_after_write got %b want 1000", {cpu_gnt, mem_wren, cpu_rvalid, dbg_rvalid});
      errors++;
    end
    idle();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h55) begin
      $display("FAIL write_readback got rv %b data %h want 1 55", cpu_rvalid, cpu_rdata);
      errors++;
    end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid();
    test_write_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
